// File: rtl/muxnway_arb_pkg.sv
// Shared constants for the arbitrated N-way mux.
// Select-width helper and arbitration mode codes.
package muxnway_arb_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/muxnway_arb_rr_arbiter.sv
// N-way arbiter, round-robin or fixed priority.
// Holds the last-grant pointer; emits one-hot grant and index.
module rr_arbiter
   import muxnway_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int RR = ARB_RR,
   localparam int SW = sel_w(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req_i,
   input  logic          upd_i,
   output logic [N-1:0]  gnt_o,
   output logic [SW-1:0] idx_o
);

   logic [SW-1:0] last_q;

   always_comb begin
      int  s;
      int  j;
      logic found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      s = (RR == ARB_RR) ? int'(last_q) + 1 : 0;
      for (int k = 0; k < N; k++) begin
         j = (s + k) % N;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = SW'(j);
         end
      end
   end

   // Pointer moves only on an accepted transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= SW'(N - 1);
      end else if (upd_i && RR == ARB_RR) begin
         last_q <= idx_o;
      end
   end

endmodule

// File: rtl/muxnway_arb.sv
// N-channel W-bit arbitrated mux with registered output stage.
// Valid/ready on every channel and on the output.
module muxnway_arb
   import muxnway_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 16,
   parameter int RR = ARB_RR,
   localparam int SW = sel_w(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   in_valid,
   input  logic [N*W-1:0] in_data,
   output logic [N-1:0]   in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_sel,
   input  logic           out_ready
);

   logic          valid_q;
   logic [W-1:0]  data_q;
   logic [SW-1:0] sel_q;
   logic [W-1:0]  data_d;
   logic [N-1:0]  gnt;
   logic [SW-1:0] idx;
   logic          load;
   logic          xfer;

   assign load     = !valid_q || out_ready;
   assign in_ready = gnt & {N{load && !reset}};
   assign xfer     = |in_ready;

   rr_arbiter #(.N(N), .RR(RR)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i (in_valid),
      .upd_i (xfer),
      .gnt_o (gnt),
      .idx_o (idx)
   );

   always_comb begin
      data_d = '0;
      for (int i = 0; i < N; i++) begin
         data_d = data_d | (in_data[i*W +: W] & {W{gnt[i]}});
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
      end else if (load) begin
         valid_q <= xfer;
         if (xfer) begin
            data_q <= data_d;
            sel_q  <= idx;
         end
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_sel   = sel_q;

endmodule

// File: tb/tb_muxnway_arb.sv
// Directed bench for muxnway_arb: RR N=4, fixed N=4, RR N=1 W=8.
module tb_muxnway_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // DUT A: N=4 W=16 round-robin
   logic        a_reset = 1'b1;
   logic [3:0]  a_valid = '0;
   logic [63:0] a_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
   logic [3:0]  a_in_ready;
   logic        a_ov;
   logic [15:0] a_od;
   logic [1:0]  a_os;
   logic        a_ready = 1'b1;

   muxnway_arb #(.N(4), .W(16), .RR(1)) dut_a (
      .clk(clk), .reset(a_reset), .in_valid(a_valid), .in_data(a_data),
      .in_ready(a_in_ready), .out_valid(a_ov), .out_data(a_od),
      .out_sel(a_os), .out_ready(a_ready)
   );

   // DUT B: N=4 W=16 fixed priority
   logic        b_reset = 1'b1;
   logic [3:0]  b_valid = '0;
   logic [63:0] b_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
   logic [3:0]  b_in_ready;
   logic        b_ov;
   logic [15:0] b_od;
   logic [1:0]  b_os;
   logic        b_ready = 1'b1;

   muxnway_arb #(.N(4), .W(16), .RR(0)) dut_b (
      .clk(clk), .reset(b_reset), .in_valid(b_valid), .in_data(b_data),
      .in_ready(b_in_ready), .out_valid(b_ov), .out_data(b_od),
      .out_sel(b_os), .out_ready(b_ready)
   );

   // DUT C: N=1 W=8 round-robin
   logic        c_reset = 1'b1;
   logic [0:0]  c_valid = '0;
   logic [7:0]  c_data  = '0;
   logic [0:0]  c_in_ready;
   logic        c_ov;
   logic [7:0]  c_od;
   logic [0:0]  c_os;
   logic        c_ready = 1'b1;

   muxnway_arb #(.N(1), .W(8), .RR(1)) dut_c (
      .clk(clk), .reset(c_reset), .in_valid(c_valid), .in_data(c_data),
      .in_ready(c_in_ready), .out_valid(c_ov), .out_data(c_od),
      .out_sel(c_os), .out_ready(c_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_a();
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
   endtask

   task automatic test_reset();
      a_reset = 1'b1;
      a_valid = 4'hF;
      a_ready = 1'b1;
      tick();
      tick();
      #1;
      checks++;
      if (a_ov !== 1'b0) begin
         errors++; $display("FAIL rst_valid got %0b want 0", a_ov);
      end
      checks++;
      if (a_od !== 16'h0000) begin
         errors++; $display("FAIL rst_data got %h want 0000", a_od);
      end
      checks++;
      if (a_os !== 2'd0) begin
         errors++; $display("FAIL rst_sel got %0d want 0", a_os);
      end
      checks++;
      if (a_in_ready !== 4'b0000) begin
         errors++; $display("FAIL rst_ready got %b want 0000", a_in_ready);
      end
      a_reset = 1'b0;
      #1;
      checks++;
      if (a_in_ready !== 4'b0001) begin
         errors++; $display("FAIL rst_first got %b want 0001", a_in_ready);
      end
   endtask

   task automatic test_rr_fairness();
      logic [1:0]  exp_sel [6] = '{0, 1, 2, 3, 0, 1};
      logic [15:0] exp_dat [6] = '{16'h1111, 16'h2222, 16'h3333,
                                   16'h4444, 16'h1111, 16'h2222};
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (a_ov !== 1'b1 || a_os !== exp_sel[k] || a_od !== exp_dat[k]) begin
            errors++;
            $display("FAIL rr_seq[%0d] got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                     k, a_ov, a_os, a_od, exp_sel[k], exp_dat[k]);
         end
      end
      a_valid = 4'h0;
      tick();
      checks++;
      if (a_ov !== 1'b0) begin
         errors++; $display("FAIL rr_drain got %0b want 0", a_ov);
      end
   endtask

   task automatic test_backpressure();
      reset_a();
      a_valid = 4'b0110;
      a_ready = 1'b0;
      tick();
      checks++;
      if (a_ov !== 1'b1 || a_od !== 16'h2222 || a_os !== 2'd1) begin
         errors++;
         $display("FAIL bp_first got v=%0b data=%h sel=%0d want v=1 data=2222 sel=1",
                  a_ov, a_od, a_os);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (a_in_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_ready[%0d] got %b want 0000", k, a_in_ready);
         end
         tick();
         checks++;
         if (a_ov !== 1'b1 || a_od !== 16'h2222 || a_os !== 2'd1) begin
            errors++;
            $display("FAIL bp_hold[%0d] got v=%0b data=%h sel=%0d want v=1 data=2222 sel=1",
                     k, a_ov, a_od, a_os);
         end
      end
      a_ready = 1'b1;
      #1;
      checks++;
      if (a_in_ready !== 4'b0100) begin
         errors++; $display("FAIL bp_release got %b want 0100", a_in_ready);
      end
      tick();
      checks++;
      if (a_ov !== 1'b1 || a_od !== 16'h3333 || a_os !== 2'd2) begin
         errors++;
         $display("FAIL bp_next got v=%0b data=%h sel=%0d want v=1 data=3333 sel=2",
                  a_ov, a_od, a_os);
      end
      a_valid = 4'h0;
      tick();
      checks++;
      if (a_ov !== 1'b0) begin
         errors++; $display("FAIL bp_drain got %0b want 0", a_ov);
      end
   endtask

   task automatic test_sparse_idle();
      reset_a();
      a_ready = 1'b1;
      a_valid = 4'b0100;
      tick();
      a_valid = 4'b0000;
      checks++;
      if (a_ov !== 1'b1 || a_od !== 16'h3333 || a_os !== 2'd2) begin
         errors++;
         $display("FAIL sp_pulse got v=%0b data=%h sel=%0d want v=1 data=3333 sel=2",
                  a_ov, a_od, a_os);
      end
      tick();
      tick();
      checks++;
      if (a_ov !== 1'b0 || a_od !== 16'h3333 || a_os !== 2'd2) begin
         errors++;
         $display("FAIL sp_idle got v=%0b data=%h sel=%0d want v=0 data=3333 sel=2",
                  a_ov, a_od, a_os);
      end
      a_valid = 4'b1001;
      #1;
      checks++;
      if (a_in_ready !== 4'b1000) begin
         errors++; $display("FAIL sp_ptr got %b want 1000", a_in_ready);
      end
      tick();
      a_valid = 4'b0000;
      checks++;
      if (a_ov !== 1'b1 || a_od !== 16'h4444 || a_os !== 2'd3) begin
         errors++;
         $display("FAIL sp_ch3 got v=%0b data=%h sel=%0d want v=1 data=4444 sel=3",
                  a_ov, a_od, a_os);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      a_ready = 1'b1;
      a_valid = 4'b0001;
      tick();
      a_ready = 1'b0;
      a_valid = 4'b0010;
      tick();
      checks++;
      if (a_ov !== 1'b1 || a_os !== 2'd0 || a_od !== 16'h1111) begin
         errors++;
         $display("FAIL mr_stall got v=%0b sel=%0d data=%h want v=1 sel=0 data=1111",
                  a_ov, a_os, a_od);
      end
      a_reset = 1'b1;
      #1;
      checks++;
      if (a_in_ready !== 4'b0000) begin
         errors++; $display("FAIL mr_ready got %b want 0000", a_in_ready);
      end
      tick();
      checks++;
      if (a_ov !== 1'b0 || a_os !== 2'd0) begin
         errors++;
         $display("FAIL mr_clear got v=%0b sel=%0d want v=0 sel=0", a_ov, a_os);
      end
      a_reset = 1'b0;
      a_ready = 1'b1;
      a_valid = 4'hF;
      #1;
      checks++;
      if (a_in_ready !== 4'b0001) begin
         errors++; $display("FAIL mr_restart got %b want 0001", a_in_ready);
      end
      tick();
      a_valid = 4'h0;
      checks++;
      if (a_ov !== 1'b1 || a_os !== 2'd0) begin
         errors++;
         $display("FAIL mr_first got v=%0b sel=%0d want v=1 sel=0", a_ov, a_os);
      end
   endtask

   task automatic test_fixed();
      b_reset = 1'b1;
      tick();
      b_reset = 1'b0;
      b_ready = 1'b1;
      b_valid = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (b_in_ready !== 4'b0001) begin
            errors++; $display("FAIL fx_ready[%0d] got %b want 0001", k, b_in_ready);
         end
         tick();
         checks++;
         if (b_ov !== 1'b1 || b_os !== 2'd0 || b_od !== 16'h1111) begin
            errors++;
            $display("FAIL fx_sel[%0d] got v=%0b sel=%0d data=%h want v=1 sel=0 data=1111",
                     k, b_ov, b_os, b_od);
         end
      end
      b_valid = 4'b1000;
      tick();
      b_valid = 4'b0000;
      checks++;
      if (b_ov !== 1'b1 || b_os !== 2'd3 || b_od !== 16'h4444) begin
         errors++;
         $display("FAIL fx_ch3 got v=%0b sel=%0d data=%h want v=1 sel=3 data=4444",
                  b_ov, b_os, b_od);
      end
   endtask

   task automatic test_n1();
      c_reset = 1'b1;
      tick();
      c_reset = 1'b0;
      c_ready = 1'b1;
      c_valid = 1'b1;
      c_data  = 8'hA5;
      #1;
      checks++;
      if (c_in_ready !== 1'b1) begin
         errors++; $display("FAIL n1_ready got %b want 1", c_in_ready);
      end
      tick();
      c_data = 8'h5A;
      checks++;
      if (c_ov !== 1'b1 || c_od !== 8'hA5 || c_os !== 1'b0) begin
         errors++;
         $display("FAIL n1_w0 got v=%0b data=%h sel=%0d want v=1 data=a5 sel=0",
                  c_ov, c_od, c_os);
      end
      tick();
      c_valid = 1'b0;
      checks++;
      if (c_ov !== 1'b1 || c_od !== 8'h5A || c_os !== 1'b0) begin
         errors++;
         $display("FAIL n1_w1 got v=%0b data=%h sel=%0d want v=1 data=5a sel=0",
                  c_ov, c_od, c_os);
      end
      tick();
      checks++;
      if (c_ov !== 1'b0) begin
         errors++; $display("FAIL n1_idle got %0b want 0", c_ov);
      end
      c_valid = 1'b1;
      c_data  = 8'h3C;
      c_ready = 1'b0;
      tick();
      #1;
      checks++;
      if (c_ov !== 1'b1 || c_od !== 8'h3C || c_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL n1_stall got v=%0b data=%h rdy=%b want v=1 data=3c rdy=0",
                  c_ov, c_od, c_in_ready);
      end
      c_reset = 1'b1;
      tick();
      c_reset = 1'b0;
      c_valid = 1'b0;
      checks++;
      if (c_ov !== 1'b0 || c_os !== 1'b0 || c_od !== 8'h00) begin
         errors++;
         $display("FAIL n1_reset got v=%0b sel=%0d data=%h want v=0 sel=0 data=00",
                  c_ov, c_os, c_od);
      end
   endtask

   initial begin
      test_reset();
      test_rr_fairness();
      test_backpressure();
      test_sparse_idle();
      test_mid_reset();
      test_fixed();
      test_n1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muxnway_arb.md
Name: muxnway_arb

Overview:
- Parametrised N-channel, W-bit arbitrated multiplexer with per-channel valid/ready handshake and a registered output stage.
- Generalises the 4-way 16-bit select mux: channel choice comes from an internal arbiter (fixed-priority or round-robin) instead of an external select line.
- Used where several producers (ALU result, memory read, I/O) compete for one 16-bit datapath bus into the CPU/register file.

Parameters:
- N, 4, number of input channels (>=1).
- W, 16, data width in bits.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N  bit i: channel i holds a word.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_ready  output  N  bit i: channel i's word is taken this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered data.
- out_sel  output  SEL_W  index of the channel that supplied out_data. SEL_W = max(1, clog2(N)).
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_data=0, out_sel=0, last_grant=N-1, so the first round-robin priority is channel 0. Any held word is discarded. in_ready is 0 while reset is high.
- Load enable: load = !out_valid || out_ready. This is a pipeline register with no bubble and throughput of 1 word/cycle.
- Grant (combinational, one-hot or zero):
  - RR=1: first valid channel searching from (last_grant+1) mod N upward with wrap-around.
  - RR=0: lowest-index valid channel.
- in_ready = grant & {N{load}}. At most one bit is set. A transfer on channel i happens when in_valid[i] && in_ready[i].
- On a transfer: out_data <= selected word, out_sel <= i, out_valid <= 1. last_grant <= i, in RR mode only.
- If load is asserted and no channel is valid: out_valid <= 0. out_data and out_sel hold their last values.
- If out_valid && !out_ready: out_data, out_sel and out_valid hold stable, and all in_ready = 0.
- Latency: 1 cycle from input transfer to out_valid.
- Simultaneous drain and refill (out_valid && out_ready && new grant): the new word loads in the same edge, so out_valid stays 1.
- last_grant updates only on an accepted transfer. Idle cycles and stall cycles do not rotate priority.
- N=1: grant = in_valid[0]. out_sel is always 0 (1 bit wide).
- Producers must hold in_data/in_valid until their in_ready is seen. Deasserting valid without a transfer is allowed; the arbiter re-evaluates every cycle.
- No combinational path from in_valid to out_*. in_ready depends combinationally on out_ready.

Decomposition:
- Shared constants header: SEL_W computation function (clog2 with minimum 1), and the mode encodings ARB_FIXED=0 / ARB_RR=1.
- Sub-module rr_arbiter, parameters N and RR. Inputs: req[N], pointer last_grant, update enable. Outputs: one-hot grant and encoded index; the last_grant register lives inside it.
- The top level holds only the output register and the data mux (AND-OR over the one-hot grant).

Test Plan (N=4, W=16 unless stated):
- Reset: hold reset 2 cycles with all in_valid=1 -> out_valid=0, out_data=0x0000, out_sel=0, in_ready=0000. After release, first grant is channel 0.
- RR fairness: all four valid continuously (data 0x1111, 0x2222, 0x3333, 0x4444), out_ready=1 -> out_sel sequence 0,1,2,3,0,1, one word per cycle with no bubbles.
- Backpressure: out_ready=0 for 3 cycles with channels 1 and 2 valid -> out_data/out_sel frozen at the first grant (0x2222, 1), in_ready=0000. After release, channel 2 (0x3333) loads on the next edge.
- Fixed priority (RR=0): channels 0 and 3 always valid -> out_sel stays 0 every cycle and channel 3 is never granted. Drop channel 0 -> out_sel becomes 3 on the next output word.
- Sparse/idle: only channel 2 valid once, then none -> a single out_valid pulse with out_data=0x3333 and out_sel=2, then out_valid=0. The next request from channel 3 is granted ahead of channel 0 (pointer preserved).
- Mid-operation reset: assert reset while out_valid=1 && out_ready=0 -> next cycle out_valid=0, out_sel=0. After release, priority restarts at channel 0. Repeat with N=1, W=8: out_sel is always 0 and data passes with 1-cycle latency.
